// File: rtl/sensor_node_responder.sv
// Sensor-node responder: accepts a hub selection request over UART and replies with echo + measurement.
// Optional build macro RESP_SINGLE_BYTE_EN: reply with the measurement byte only (no echo).
module sensor_node_responder #(
    parameter int unsigned CLK_FREQ          = 25_000_000,
    parameter logic [3:0]  CMD_HDR           = 4'hA,
    parameter int unsigned RX_GAP_CYCLES     = CLK_FREQ / 500,
    parameter int unsigned TX_TIMEOUT_CYCLES = CLK_FREQ / 100
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_rx_dv,
    input  logic [7:0]   i_rx_byte,
    output logic         o_tx_dv,
    output logic [7:0]   o_tx_byte,
    input  logic         i_tx_active,
    input  logic         i_tx_done,
    input  logic [127:0] i_sensor_data,
    output logic         o_busy,
    output logic [3:0]   o_last_sel,
    output logic [15:0]  o_req_count,
    output logic [7:0]   o_drop_count
);

    localparam int unsigned GAP_W = (RX_GAP_CYCLES > 1) ? $clog2(RX_GAP_CYCLES) : 1;
    localparam int unsigned TO_W  = (TX_TIMEOUT_CYCLES > 1) ? $clog2(TX_TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RX_GAP_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TX_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_GAP,
        S_SNAP,
        S_TX1,
        S_TX1_W,
        S_TX2,
        S_TX2_W
    } state_t;

    state_t           r_state;
    logic [7:0]       r_req;
    logic [7:0]       r_meas;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_tx_dv;
    logic [7:0]       r_tx_byte;
    logic             r_busy;
    logic [3:0]       r_last_sel;
    logic [15:0]      r_req_count;
    logic [7:0]       r_drop_count;

    state_t           w_state_nxt;
    logic [7:0]       w_req_nxt;
    logic [7:0]       w_meas_nxt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic [TO_W-1:0]  w_to_nxt;
    logic             w_tx_dv_nxt;
    logic [7:0]       w_tx_byte_nxt;
    logic             w_busy_nxt;
    logic [3:0]       w_last_sel_nxt;
    logic [15:0]      w_req_count_nxt;
    logic [7:0]       w_drop_count_nxt;
    logic             w_drop_inc;
    logic [7:0]       w_sel_entry;

    assign w_sel_entry = i_sensor_data[{r_req[3:0], 3'b000} +: 8];

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req        <= 8'd0;
            r_meas       <= 8'd0;
            r_gap_cnt    <= '0;
            r_to_cnt     <= '0;
            r_tx_dv      <= 1'b0;
            r_tx_byte    <= 8'd0;
            r_busy       <= 1'b0;
            r_last_sel   <= 4'd0;
            r_req_count  <= 16'd0;
            r_drop_count <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_req        <= w_req_nxt;
            r_meas       <= w_meas_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_to_cnt     <= w_to_nxt;
            r_tx_dv      <= w_tx_dv_nxt;
            r_tx_byte    <= w_tx_byte_nxt;
            r_busy       <= w_busy_nxt;
            r_last_sel   <= w_last_sel_nxt;
            r_req_count  <= w_req_count_nxt;
            r_drop_count <= w_drop_count_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_req_nxt       = r_req;
        w_meas_nxt      = r_meas;
        w_gap_nxt       = r_gap_cnt;
        w_to_nxt        = r_to_cnt;
        w_tx_dv_nxt     = 1'b0;
        w_tx_byte_nxt   = r_tx_byte;
        w_last_sel_nxt  = r_last_sel;
        w_req_count_nxt = r_req_count;
        w_drop_inc      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_rx_dv) begin
                    if (i_rx_byte[7:4] == CMD_HDR) begin
                        w_req_nxt      = i_rx_byte;
                        w_last_sel_nxt = i_rx_byte[3:0];
                        w_gap_nxt      = '0;
                        w_state_nxt    = S_RX_GAP;
                    end else begin
                        w_drop_inc = 1'b1;
                    end
                end
            end
            S_RX_GAP: begin
                // A trailing byte ends the window early, even on the terminal count.
                if (i_rx_dv || (r_gap_cnt == GAP_LAST)) begin
                    w_state_nxt = S_SNAP;
                end else begin
                    w_gap_nxt = r_gap_cnt + GAP_W'(1);
                end
            end
            S_SNAP: begin
                w_drop_inc      = i_rx_dv;
                w_meas_nxt      = w_sel_entry;
                w_req_count_nxt = r_req_count + 16'd1;
`ifdef RESP_SINGLE_BYTE_EN
                w_state_nxt     = S_TX2;
`else
                w_state_nxt     = S_TX1;
`endif
            end
            S_TX1: begin
                w_drop_inc = i_rx_dv;
                if (!i_tx_active) begin
                    w_tx_dv_nxt   = 1'b1;
                    w_tx_byte_nxt = r_req;
                    w_to_nxt      = '0;
                    w_state_nxt   = S_TX1_W;
                end
            end
            S_TX1_W: begin
                w_drop_inc = i_rx_dv;
                if (i_tx_done) begin
                    w_state_nxt = S_TX2;
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_TX2: begin
                w_drop_inc = i_rx_dv;
                if (!i_tx_active) begin
                    w_tx_dv_nxt   = 1'b1;
                    w_tx_byte_nxt = r_meas;
                    w_to_nxt      = '0;
                    w_state_nxt   = S_TX2_W;
                end
            end
            S_TX2_W: begin
                w_drop_inc = i_rx_dv;
                if (i_tx_done || (r_to_cnt == TO_LAST)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_to_nxt = r_to_cnt + TO_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt       = (w_state_nxt != S_IDLE);
        w_drop_count_nxt = (w_drop_inc && (r_drop_count != 8'hFF)) ? r_drop_count + 8'd1
                                                                     : r_drop_count;
    end

    assign o_tx_dv      = r_tx_dv;
    assign o_tx_byte    = r_tx_byte;
    assign o_busy       = r_busy;
    assign o_last_sel   = r_last_sel;
    assign o_req_count  = r_req_count;
    assign o_drop_count = r_drop_count;

endmodule

// File: tb/tb_sensor_node_responder.sv
// Scoreboard bench for sensor_node_responder with a simple uart_top TX model (done 10 cycles after strobe).
module tb_sensor_node_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_rx_dv;
    logic [7:0]   i_rx_byte;
    logic         o_tx_dv;
    logic [7:0]   o_tx_byte;
    logic         i_tx_active;
    logic         i_tx_done;
    logic [127:0] sens;
    logic         o_busy;
    logic [3:0]   o_last_sel;
    logic [15:0]  o_req_count;
    logic [7:0]   o_drop_count;

    logic         model_active = 1'b0;
    logic         model_done   = 1'b0;
    logic         hold_active  = 1'b0;
    logic         withhold_done = 1'b0;
    int           done_cnt = 0;

    int           checks = 0;
    int           errors = 0;
    int           n_strobes = 0;
    logic         prev_dv = 1'b0;
    logic [7:0]   exp_q[$];

    assign i_tx_active = model_active | hold_active;
    assign i_tx_done   = model_done;

    always #5 clk = ~clk;

    sensor_node_responder #(
        .RX_GAP_CYCLES     (20),
        .TX_TIMEOUT_CYCLES (200)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rx_dv       (i_rx_dv),
        .i_rx_byte     (i_rx_byte),
        .o_tx_dv       (o_tx_dv),
        .o_tx_byte     (o_tx_byte),
        .i_tx_active   (i_tx_active),
        .i_tx_done     (i_tx_done),
        .i_sensor_data (sens),
        .o_busy        (o_busy),
        .o_last_sel    (o_last_sel),
        .o_req_count   (o_req_count),
        .o_drop_count  (o_drop_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] entry(input logic [3:0] k);
        return sens[k*8 +: 8];
    endfunction

    task automatic push_reply(input logic [7:0] req);
`ifndef RESP_SINGLE_BYTE_EN
        exp_q.push_back(req);
`endif
        exp_q.push_back(entry(req[3:0]));
    endtask

    task automatic push_first(input logic [7:0] req);
`ifdef RESP_SINGLE_BYTE_EN
        exp_q.push_back(entry(req[3:0]));
`else
        exp_q.push_back(req);
`endif
    endtask

    task automatic send_rx(input logic [7:0] b);
        i_rx_byte = b;
        i_rx_dv   = 1'b1;
        @(negedge clk);
        i_rx_dv   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (o_busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(o_busy), 32'(0));
        check_val({tag, "_q"}, 32'(exp_q.size()), 32'(0));
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        while (!o_tx_dv && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 32'(o_tx_dv), 32'(1));
        @(negedge clk);
    endtask

    // uart_top TX model
    always @(negedge clk) begin
        model_done = 1'b0;
        if (!rst_n) begin
            model_active = 1'b0;
            done_cnt     = 0;
        end else if (o_tx_dv) begin
            model_active = 1'b1;
            done_cnt     = 10;
        end else if (done_cnt != 0) begin
            done_cnt--;
            if (done_cnt == 0) begin
                model_active = 1'b0;
                model_done   = !withhold_done;
            end
        end
    end

    // Scoreboard: every strobe must match the next expected byte
    always @(negedge clk) begin
        logic [7:0] exp;
        if (o_tx_dv) begin
            n_strobes++;
            check_val("tx_dv_back_to_back", 32'(prev_dv), 32'(0));
            if (exp_q.size() == 0) begin
                check_val("tx_unexpected", 32'(o_tx_byte), 32'hFFFF_FFFF);
            end else begin
                exp = exp_q.pop_front();
                check_val("tx_byte", 32'(o_tx_byte), 32'(exp));
            end
        end
        prev_dv = o_tx_dv;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        logic [7:0] old5;

        rst_n     = 1'b0;
        i_rx_dv   = 1'b0;
        i_rx_byte = 8'h00;
        for (int k = 0; k < 16; k++) sens[k*8 +: 8] = 8'($urandom);
        sens[6*8 +: 8] = 8'h5C;
        repeat (3) @(negedge clk);
        check_val("rst_tx_dv", 32'(o_tx_dv), 32'(0));
        check_val("rst_tx_byte", 32'(o_tx_byte), 32'(0));
        check_val("rst_busy", 32'(o_busy), 32'(0));
        check_val("rst_last_sel", 32'(o_last_sel), 32'(0));
        check_val("rst_req_count", 32'(o_req_count), 32'(0));
        check_val("rst_drop_count", 32'(o_drop_count), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single request, full gap window
        push_reply(8'hA6);
        send_rx(8'hA6);
        check_val("t1_busy", 32'(o_busy), 32'(1));
        check_val("t1_last_sel", 32'(o_last_sel), 32'(6));
        repeat (18) @(negedge clk);
        check_val("t1_no_early_tx", 32'(n_strobes), 32'(0));
        wait_idle("t1_idle");
        check_val("t1_req_count", 32'(o_req_count), 32'(1));
        check_val("t1_strobes", 32'(n_strobes), 32'(2));

        // Trailing byte is discarded
        push_reply(8'hA3);
        send_rx(8'hA3);
        repeat (3) @(negedge clk);
        send_rx(8'h77);
        wait_idle("t2_idle");
        check_val("t2_drop_count", 32'(o_drop_count), 32'(0));
        check_val("t2_req_count", 32'(o_req_count), 32'(2));
        check_val("t2_last_sel", 32'(o_last_sel), 32'(3));

        // Bad header
        base = n_strobes;
        send_rx(8'h53);
        check_val("t3_busy", 32'(o_busy), 32'(0));
        check_val("t3_drop_count", 32'(o_drop_count), 32'(1));
        repeat (30) @(negedge clk);
        check_val("t3_req_count", 32'(o_req_count), 32'(2));
        check_val("t3_no_tx", 32'(n_strobes), 32'(base));

        // Transmitter busy delays the first strobe; snapshot survives entry change
        base = n_strobes;
        hold_active = 1'b1;
        old5 = entry(4'h5);
        push_reply(8'hA5);
        send_rx(8'hA5);
        repeat (70) @(negedge clk);
        check_val("t4_held", 32'(n_strobes), 32'(base));
        hold_active = 1'b0;
        @(negedge clk);
        check_val("t4_dv_after_active", 32'(o_tx_dv), 32'(1));
        sens[5*8 +: 8] = ~old5;
        wait_idle("t4_idle");
        check_val("t4_req_count", 32'(o_req_count), 32'(3));

        // TX timeout, then normal service
        base = n_strobes;
        withhold_done = 1'b1;
        push_first(8'hA2);
        send_rx(8'hA2);
        n = 0;
        while (!o_tx_dv && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_first_strobe", 32'(o_tx_dv), 32'(1));
        n = 0;
        while (o_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_timeout_cycles", 32'(n), 32'(200));
        withhold_done = 1'b0;
        repeat (20) @(negedge clk);
        check_val("t5_one_strobe", 32'(n_strobes), 32'(base + 1));
        push_reply(8'hAF);
        send_rx(8'hAF);
        wait_idle("t5_idle");
        check_val("t5_last_sel", 32'(o_last_sel), 32'(15));

        // Byte during TX2_W is dropped
        base = n_strobes;
        n = int'(o_drop_count);
        push_reply(8'hA4);
        send_rx(8'hA4);
        wait_strobe("t6_strobe1");
`ifndef RESP_SINGLE_BYTE_EN
        wait_strobe("t6_strobe2");
`endif
        send_rx(8'hA1);
        wait_idle("t6_idle");
        check_val("t6_drop_count", 32'(o_drop_count), 32'(n + 1));
        check_val("t6_last_sel", 32'(o_last_sel), 32'(4));

        // Request for entry 0
        push_reply(8'hA0);
        send_rx(8'hA0);
        wait_idle("t7_idle");

        // Reset mid-transfer
        base = n_strobes;
        push_first(8'hA7);
        send_rx(8'hA7);
        wait_strobe("t8_strobe");
        rst_n = 1'b0;
        @(negedge clk);
        check_val("t8_tx_dv", 32'(o_tx_dv), 32'(0));
        check_val("t8_tx_byte", 32'(o_tx_byte), 32'(0));
        check_val("t8_busy", 32'(o_busy), 32'(0));
        check_val("t8_last_sel", 32'(o_last_sel), 32'(0));
        check_val("t8_req_count", 32'(o_req_count), 32'(0));
        check_val("t8_drop_count", 32'(o_drop_count), 32'(0));
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_val("t8_no_more_tx", 32'(n_strobes), 32'(base + 1));
        check_val("t8_q", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
